// File: rtl/hwpe_ctrl_loop_nest.sv
// Nested-loop offset generator: walks NB_LOOPS counters (loop 0 innermost) and streams
// base + sum(idx*stride). Stride of loop l, reg r sits at bits [(l*NB_REG+r)*REG_WIDTH +: REG_WIDTH].
module hwpe_ctrl_loop_nest #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 12,
  localparam int unsigned LOOP_W   = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 abort_i,
  input  logic                                 cfg_valid_i,
  output logic                                 cfg_ready_o,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]        cfg_range_i,
  input  logic [NB_LOOPS*NB_REG*REG_WIDTH-1:0] cfg_stride_i,
  input  logic [NB_REG*REG_WIDTH-1:0]          cfg_base_i,
  input  logic                                 start_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]          out_offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]        out_idx_o,
  output logic [LOOP_W-1:0]                    out_loop_o,
  output logic                                 out_last_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int unsigned RANGE_W  = NB_LOOPS*CNT_WIDTH;
  localparam int unsigned STRIDE_W = NB_LOOPS*NB_REG*REG_WIDTH;
  localparam int unsigned OFFS_W   = NB_REG*REG_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic                 shadowFull_q, shadowFull_d;
  logic [RANGE_W-1:0]   shRange_q, shRange_d, range_q, range_d;
  logic [STRIDE_W-1:0]  shStride_q, shStride_d, stride_q, stride_d;
  logic [OFFS_W-1:0]    shBase_q, shBase_d;
  logic [OFFS_W-1:0]    offs_q, offs_d;
  logic [RANGE_W-1:0]   idx_q, idx_d;
  logic [LOOP_W-1:0]    loop_q, loop_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  // saved_q[l] holds the offset at the start of loop l's current iteration (all lower indices 0)
  logic [REG_WIDTH-1:0] saved_q [NB_LOOPS][NB_REG];
  logic [REG_WIDTH-1:0] saved_d [NB_LOOPS][NB_REG];

  logic [CNT_WIDTH-1:0] maxIdx [NB_LOOPS];
  logic [LOOP_W-1:0]    advLvl;
  logic [RANGE_W-1:0]   advIdx;
  logic [OFFS_W-1:0]    advOffs;
  logic                 advLast;
  logic                 startLast;

  for (genvar g = 0; g < NB_LOOPS; g++) begin : gMax
    assign maxIdx[g] = (range_q[g*CNT_WIDTH +: CNT_WIDTH] == '0) ? '0
                     : range_q[g*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
  end

  // Successor of the current beat: lowest non-saturated loop steps, everything below it rewinds
  always_comb begin
    advLvl    = '0;
    advIdx    = idx_q;
    advOffs   = '0;
    advLast   = 1'b1;
    startLast = 1'b1;
    for (int l = NB_LOOPS - 1; l >= 0; l--) begin
      if (idx_q[l*CNT_WIDTH +: CNT_WIDTH] < maxIdx[l]) advLvl = LOOP_W'(l);
    end
    for (int l = 0; l < NB_LOOPS; l++) begin
      if (LOOP_W'(l) < advLvl) begin
        advIdx[l*CNT_WIDTH +: CNT_WIDTH] = '0;
      end else if (LOOP_W'(l) == advLvl) begin
        advIdx[l*CNT_WIDTH +: CNT_WIDTH] = idx_q[l*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
      if (advIdx[l*CNT_WIDTH +: CNT_WIDTH] != maxIdx[l]) advLast = 1'b0;
      if (shRange_q[l*CNT_WIDTH +: CNT_WIDTH] > CNT_WIDTH'(1)) startLast = 1'b0;
      if (LOOP_W'(l) == advLvl) begin
        for (int r = 0; r < NB_REG; r++) begin
          advOffs[r*REG_WIDTH +: REG_WIDTH] = saved_q[l][r]
                                            + stride_q[(l*NB_REG + r)*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shadowFull_d = shadowFull_q;
    shRange_d    = shRange_q;
    shStride_d   = shStride_q;
    shBase_d     = shBase_q;
    range_d      = range_q;
    stride_d     = stride_q;
    offs_d       = offs_q;
    idx_d        = idx_q;
    loop_d       = loop_q;
    valid_d      = valid_q;
    last_d       = last_q;
    done_d       = 1'b0;
    saved_d      = saved_q;

    if (cfg_valid_i && !shadowFull_q) begin
      shRange_d    = cfg_range_i;
      shStride_d   = cfg_stride_i;
      shBase_d     = cfg_base_i;
      shadowFull_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i && shadowFull_q) begin
          state_d      = RUN;
          shadowFull_d = 1'b0;
          range_d      = shRange_q;
          stride_d     = shStride_q;
          offs_d       = shBase_q;
          idx_d        = '0;
          loop_d       = '0;
          valid_d      = 1'b1;
          last_d       = startLast;
          for (int l = 0; l < NB_LOOPS; l++) begin
            for (int r = 0; r < NB_REG; r++) saved_d[l][r] = shBase_q[r*REG_WIDTH +: REG_WIDTH];
          end
        end
      end
      RUN: begin
        if (out_ready_i) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = advIdx;
            offs_d = advOffs;
            loop_d = advLvl;
            last_d = advLast;
            for (int l = 0; l < NB_LOOPS; l++) begin
              if (LOOP_W'(l) <= advLvl) begin
                for (int r = 0; r < NB_REG; r++) saved_d[l][r] = advOffs[r*REG_WIDTH +: REG_WIDTH];
              end
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over start and handshake; a pending shadow survives it
    if (abort_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      if (shadowFull_q) shadowFull_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      shadowFull_q <= 1'b0;
      offs_q       <= '0;
      idx_q        <= '0;
      loop_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadowFull_q <= shadowFull_d;
      offs_q       <= offs_d;
      idx_q        <= idx_d;
      loop_q       <= loop_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shRange_q  <= shRange_d;
    shStride_q <= shStride_d;
    shBase_q   <= shBase_d;
    range_q    <= range_d;
    stride_q   <= stride_d;
    saved_q    <= saved_d;
  end

  assign cfg_ready_o = !shadowFull_q;
  assign out_valid_o = valid_q;
  assign out_offs_o  = offs_q;
  assign out_idx_o   = idx_q;
  assign out_loop_o  = loop_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_hwpe_ctrl_loop_nest.sv
// Bench for hwpe_ctrl_loop_nest: directed cycle table plus runs checked against an
// odometer-style reference model (index from beat number, offsets by multiplication).
module tb_hwpe_ctrl_loop_nest;
  localparam int NL = 6, NR = 4, RW = 32, CW = 12, LW = 3;

  typedef struct {
    logic [NL*CW-1:0]    rng;
    logic [NL*NR*RW-1:0] str;
    logic [NR*RW-1:0]    base;
  } cfg_t;

  typedef struct {
    logic          ready;
    logic [RW-1:0] offs0;
    logic [LW-1:0] loop;
    logic          last;
  } vec_t;

  logic clk = 1'b0;
  logic rst, abort, cfgValid, cfgReady, start, outValid, outReady, outLast, busy, done;
  logic [NL*CW-1:0]    cfgRange;
  logic [NL*NR*RW-1:0] cfgStride;
  logic [NR*RW-1:0]    cfgBase, outOffs;
  logic [NL*CW-1:0]    outIdx;
  logic [LW-1:0]       outLoop;
  int total = 0;
  int bad = 0;

  hwpe_ctrl_loop_nest #(.NB_LOOPS(NL), .NB_REG(NR), .REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .abort_i(abort), .cfg_valid_i(cfgValid), .cfg_ready_o(cfgReady),
    .cfg_range_i(cfgRange), .cfg_stride_i(cfgStride), .cfg_base_i(cfgBase), .start_i(start),
    .out_valid_o(outValid), .out_ready_i(outReady), .out_offs_o(outOffs), .out_idx_o(outIdx),
    .out_loop_o(outLoop), .out_last_o(outLast), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Beat n of a run: mixed-radix decomposition of n, loop = highest index that moved
  function automatic void modelBeat(input cfg_t c, input int n, output logic [NR*RW-1:0] offs,
                                    output logic [NL*CW-1:0] idx, output logic [LW-1:0] loop,
                                    output logic last);
    int div, rad;
    int cur [NL];
    int prv [NL];
    logic [RW-1:0] acc;
    div = 1;
    for (int l = 0; l < NL; l++) begin
      rad = (c.rng[l*CW +: CW] == 0) ? 1 : int'(c.rng[l*CW +: CW]);
      cur[l] = (n / div) % rad;
      prv[l] = (n > 0) ? ((n - 1) / div) % rad : 0;
      div = div * rad;
    end
    last = (n == div - 1);
    loop = '0;
    for (int l = 0; l < NL; l++) begin
      if (cur[l] != prv[l]) loop = LW'(l);
      idx[l*CW +: CW] = CW'(cur[l]);
    end
    for (int r = 0; r < NR; r++) begin
      acc = c.base[r*RW +: RW];
      for (int l = 0; l < NL; l++) acc = acc + RW'(cur[l]) * c.str[(l*NR + r)*RW +: RW];
      offs[r*RW +: RW] = acc;
    end
  endfunction

  task automatic applyStimulus(input cfg_t c);
    cfgRange  = c.rng;
    cfgStride = c.str;
    cfgBase   = c.base;
    cfgValid  = 1'b1;
    @(negedge clk);
    cfgValid  = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows a run already presenting beat 0; abortAt >= 0 aborts while that beat is shown
  task automatic runCheck(input cfg_t c, input int readyPct, input int abortAt, input string tag);
    logic [NR*RW-1:0] eOffs;
    logic [NL*CW-1:0] eIdx;
    logic [LW-1:0]    eLoop;
    logic             eLast, stalled;
    logic [255:0]     prevSnap;
    int n, cyc;
    n = 0; cyc = 0; stalled = 1'b0; prevSnap = '0;
    forever begin
      modelBeat(c, n, eOffs, eIdx, eLoop, eLast);
      checkOutput({tag, " beat"}, {outValid, outOffs, outIdx, outLoop, outLast},
                  {1'b1, eOffs, eIdx, eLoop, eLast});
      if (stalled) checkOutput({tag, " stall"}, {outValid, outOffs, outIdx, outLoop, outLast}, prevSnap);
      prevSnap = {outValid, outOffs, outIdx, outLoop, outLast};
      if (n == abortAt) begin
        abort = 1'b1; outReady = 1'b1;
        @(negedge clk);
        abort = 1'b0; outReady = 1'b0;
        checkOutput({tag, " abort"}, {outValid, done, busy}, 3'b000);
        @(negedge clk);
        checkOutput({tag, " abort no done"}, {outValid, done, busy}, 3'b000);
        return;
      end
      outReady = ($urandom_range(99) < readyPct);
      stalled  = !outReady;
      @(negedge clk);
      if (!stalled) begin
        if (eLast) begin
          outReady = 1'b0;
          checkOutput({tag, " done pulse"}, {outValid, done, busy}, 3'b010);
          @(negedge clk);
          checkOutput({tag, " done end"}, {outValid, done, busy}, 3'b000);
          return;
        end
        n++;
      end
      cyc++;
      if (cyc > 20000) begin
        total++; bad++;
        $display("[TB] FAIL %s timeout: beats=%0d, want run end", tag, n);
        outReady = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    cfg_t cA, cB, cC, cZero, cOne, cWrap, cR;
    vec_t tbl [8];

    tbl[0] = '{1'b1, 32'h1000, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 32'h1004, 3'd0, 1'b0};
    tbl[2] = '{1'b1, 32'h1004, 3'd0, 1'b0};
    tbl[3] = '{1'b1, 32'h1008, 3'd0, 1'b0};
    tbl[4] = '{1'b1, 32'h1064, 3'd1, 1'b0};
    tbl[5] = '{1'b0, 32'h1068, 3'd0, 1'b0};
    tbl[6] = '{1'b1, 32'h1068, 3'd0, 1'b0};
    tbl[7] = '{1'b1, 32'h106C, 3'd0, 1'b1};

    cA.rng = '0; cA.str = '0; cA.base = '0;
    cA.rng[0*CW +: CW] = 12'd3;
    cA.rng[1*CW +: CW] = 12'd2;
    cA.str[(0*NR + 0)*RW +: RW] = 32'h4;
    cA.str[(1*NR + 0)*RW +: RW] = 32'h64;
    cA.str[(0*NR + 1)*RW +: RW] = 32'h1;
    cA.base[0 +: RW]  = 32'h1000;
    cA.base[RW +: RW] = 32'h20;

    cB.rng = '0; cB.str = '0; cB.base = {32'h4000, 32'h3000, 32'h2000, 32'h0};
    cB.rng[0*CW +: CW] = 12'd2;
    cB.rng[2*CW +: CW] = 12'd3;
    for (int i = 0; i < NL*NR; i++) cB.str[i*RW +: RW] = RW'(i * 3 + 1);

    cC = cB;
    cC.base = '1;

    cZero.rng = '0; cZero.str = '1; cZero.base = {32'hDEAD, 32'hBEEF, 32'h1234, 32'h5678};
    cOne = cZero;
    for (int l = 0; l < NL; l++) cOne.rng[l*CW +: CW] = 12'd1;

    cWrap.rng = '0; cWrap.str = '0; cWrap.base = '0;
    cWrap.rng[0 +: CW]  = 12'd2;
    cWrap.str[0 +: RW]  = 32'h10;
    cWrap.base[0 +: RW] = 32'hFFFF_FFF0;

    rst = 1'b1; abort = 1'b0; cfgValid = 1'b0; start = 1'b0; outReady = 1'b0;
    cfgRange = '0; cfgStride = '0; cfgBase = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset", {outValid, outOffs, outIdx, outLoop, outLast, busy, done, cfgReady}, 1);
    rst = 1'b0;
    @(negedge clk);

    startRun();
    checkOutput("start without cfg", {busy, outValid, done}, 3'b000);

    applyStimulus(cA);
    checkOutput("shadow full", cfgReady, 0);
    startRun();
    checkOutput("shadow freed", {cfgReady, busy}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("table %0d", i), {outValid, outOffs[RW-1:0], outLoop, outLast},
                  {1'b1, tbl[i].offs0, tbl[i].loop, tbl[i].last});
      outReady = tbl[i].ready;
      @(negedge clk);
    end
    outReady = 1'b0;
    checkOutput("table done", {outValid, done, busy}, 3'b010);
    @(negedge clk);
    checkOutput("table done one cycle", {outValid, done, busy}, 3'b000);

    applyStimulus(cA);
    startRun();
    runCheck(cA, 50, -1, "half ready");

    applyStimulus(cA);
    startRun();
    applyStimulus(cB);
    checkOutput("B pending", cfgReady, 0);
    applyStimulus(cC);
    runCheck(cA, 100, -1, "A with B pending");
    checkOutput("B still pending", cfgReady, 0);
    startRun();
    runCheck(cB, 70, -1, "B run");
    checkOutput("shadow empty after B", cfgReady, 1);

    applyStimulus(cZero);
    startRun();
    runCheck(cZero, 100, -1, "ranges 0");
    applyStimulus(cOne);
    startRun();
    runCheck(cOne, 60, -1, "ranges 1");

    applyStimulus(cWrap);
    startRun();
    checkOutput("wrap beat0", outOffs[RW-1:0], 32'hFFFF_FFF0);
    runCheck(cWrap, 100, -1, "wrap");

    applyStimulus(cA);
    startRun();
    applyStimulus(cA);
    runCheck(cA, 100, 2, "abort");
    checkOutput("shadow kept", cfgReady, 0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checkOutput("abort beats start", {busy, outValid, cfgReady}, 3'b000);
    startRun();
    runCheck(cA, 100, -1, "rerun");

    for (int k = 0; k < 6; k++) begin
      for (int l = 0; l < NL; l++) cR.rng[l*CW +: CW] = CW'($urandom_range(0, (l < 3) ? 4 : 2));
      for (int i = 0; i < NL*NR; i++) cR.str[i*RW +: RW] = $urandom();
      for (int r = 0; r < NR; r++) cR.base[r*RW +: RW] = $urandom();
      applyStimulus(cR);
      startRun();
      runCheck(cR, int'($urandom_range(30, 100)), -1, $sformatf("random %0d", k));
    end

    applyStimulus(cA);
    startRun();
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    outReady = 1'b0;
    applyStimulus(cB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset mid-run", {outValid, outOffs, outIdx, outLoop, outLast, busy, done, cfgReady}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
